vec_packer: RTL
===============

# vec_packer

Byte-stream to vector packer sitting directly upstream of the `ads` 255-bit ones-counter. Accepts 32 byte beats over a valid/ready handshake and assembles them little-endian into one 255-bit vector. It holds the vector stable with `vec_valid` until the downstream stage takes it. Framing is marked by `din_first`; framing violations raise a sticky error flag.

## Interface
- Parameters: none. Widths are fixed: 8-bit beats, 32 beats per frame, 255-bit vector.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `clear`  in  1  synchronous abort/flush; dominates every other input except `rst`.
- `din`  in  8  data byte.
- `din_valid`  in  1  `din`/`din_first` valid.
- `din_first`  in  1  marks byte 0 of a frame.
- `din_ready`  out  1  packer can accept a beat (registered).
- `vec`  out  255  assembled vector (registered); meaningful only while `vec_valid`=1.
- `vec_valid`  out  1  `vec` holds a complete frame.
- `vec_ready`  in  1  downstream takes `vec`.
- `beat_cnt`  out  5  beats accepted in the current frame (0..31).
- `err`  out  1  sticky framing error.

## Operation
- Beat accept: `din_valid & din_ready` at a rising edge.
- Packing: beat k (k=0..30) writes `vec[8k+7:8k]` = `din`.
  - Beat 31 writes `vec[254:248]` = `din[6:0]`; `din[7]` of beat 31 is discarded.
  - Bits not yet written in a frame keep their previous contents.
- Two states:
  - FILL: `din_ready`=1, `vec_valid`=0.
    - Each accept sets `beat_cnt` to `beat_cnt`+1.
    - The accept at `beat_cnt`=31 moves the block to HOLD and sets `beat_cnt` to 0.
  - HOLD: `din_ready`=0, `vec_valid`=1, `vec` frozen.
    - `vec_ready`=1 moves the block to FILL.
- Framing:
  - Accept with `din_first`=1 while `beat_cnt`≠0: the frame restarts. The byte is stored as beat 0, `beat_cnt`=1, `err` is set.
  - Accept with `din_first`=0 while `beat_cnt`=0: the byte is stored as beat 0 and `err` is set.
  - `din_first`=1 at `beat_cnt`=0 is the normal case; `err` is unchanged.
- `err` is cleared only by `rst` or `clear`.
- `clear`: at the next edge, state=FILL, `beat_cnt`=0, `vec`=0, `vec_valid`=0, `err`=0, `din_ready`=1. Any beat or `vec_ready` presented in that cycle is ignored.
- `din_valid` or `din_first` while `din_ready`=0 has no effect.
- `vec_ready` while `vec_valid`=0 has no effect.

## Timing
- Reset values: `din_ready`=0, `vec_valid`=0, `vec`=0, `beat_cnt`=0, `err`=0, state=FILL.
- `din_ready` rises at the first rising edge after `rst` deasserts.
- Latency: `vec_valid` and `vec` update at the same edge that accepts beat 31. `din_ready` falls at that same edge. Throughput is zero wait states within a frame.
- A HOLD→FILL handshake at edge N gives `vec_valid`=0 and `din_ready`=1 after N. The first beat of the next frame is accepted at edge N+1 at the earliest, so the minimum frame period is 33 cycles.
- `vec` is stable from `vec_valid` rise until the handshake edge; downstream combinational logic may sample it at any cycle in between.
- `rst` asserted mid-frame or in HOLD: all outputs go to reset values immediately (asynchronously) and the partial frame is lost.
- `clear` and `vec_ready` in the same HOLD cycle: `clear` wins. Result is identical to clear alone; the frame is counted as not delivered.
- `clear` and an accepted beat in the same cycle: the beat is dropped.

## Test plan
- Reset and basic frame: after reset, check `din_ready`=0, then 1 one cycle after deassert. Send bytes 0xAA, 0xAA (first on beat 0), then 30 × 0x00, with `vec_ready`=1. Expect `vec_valid` for exactly one cycle after beat 31 with `vec`=255'haaaa; downstream count is 8.
- Full pattern with backpressure: 32 × 0xAA with `vec_ready`=0 for 5 cycles. Expect `vec` = 0x2A in bits [254:248] and 0xAA in every other byte (count 127). `vec` holds for all 5 cycles. `din_ready`=0 throughout and `din_valid` pulses are ignored.
- Bit-255 drop: beat 31 = 0xFF, others 0x00. Expect `vec`=255'h7F<<248 and `vec[254]`=1; no bit beyond 254 exists.
- Framing error: `din_first`=1 on beat 10. Expect `err`=1, `beat_cnt`=1, and the frame completes 31 beats later. `err` stays 1 until `clear`, then reads 0.
- Bubbles: random `din_valid` gaps across a frame of incrementing bytes 0x00..0x1F. Expect `vec[8k+7:8k]`=k for k=0..30, `vec[254:248]`=0x1F, and `beat_cnt` tracking only accepted beats.
- Mid-operation reset/clear: assert `rst` asynchronously at beat 17, and separately assert `clear` in HOLD together with `vec_ready`. Both must yield `vec`=0, `vec_valid`=0, `beat_cnt`=0, and a next frame that packs correctly from beat 0.

Source files
------------

// File: rtl/vec_packer.sv
// Byte-stream to 255-bit vector packer: 32 little-endian byte beats form one vector,
// held with vec_valid until downstream takes it. Framing violations set a sticky err.
module vec_packer (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [7:0]   din,
    input  logic         din_valid,
    input  logic         din_first,
    output logic         din_ready,
    output logic [254:0] vec,
    output logic         vec_valid,
    input  logic         vec_ready,
    output logic [4:0]   beat_cnt,
    output logic         err
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t         state_q,     state_d;
    logic           din_ready_q, din_ready_d;
    logic           vec_valid_q, vec_valid_d;
    logic [254:0]   vec_q,       vec_d;
    logic [4:0]     beat_cnt_q,  beat_cnt_d;
    logic           err_q,       err_d;

    logic           accept_s;
    logic [4:0]     slot_s;
    logic [254:0]   vec_pack_s;

    assign accept_s = din_valid & din_ready_q & (state_q == ST_FILL);

    // A first-marker, or any beat arriving with no frame open, lands in slot 0.
    assign slot_s = (din_first || (beat_cnt_q == 5'd0)) ? 5'd0 : beat_cnt_q;

    // Current vector with the incoming byte merged into its slot; slot 31 keeps only din[6:0].
    always_comb begin
        vec_pack_s = vec_q;
        for (int k = 0; k < 31; k++) begin
            vec_pack_s[8*k +: 8] = (slot_s == 5'(k)) ? din : vec_q[8*k +: 8];
        end
        vec_pack_s[254:248] = (slot_s == 5'd31) ? din[6:0] : vec_q[254:248];
    end

    // Next-state and next-output logic; clear overrides everything.
    always_comb begin
        state_d     = state_q;
        din_ready_d = din_ready_q;
        vec_valid_d = vec_valid_q;
        vec_d       = vec_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;

        if (clear) begin
            state_d     = ST_FILL;
            din_ready_d = 1'b1;
            vec_valid_d = 1'b0;
            vec_d       = 255'd0;
            beat_cnt_d  = 5'd0;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    din_ready_d = 1'b1;
                    vec_valid_d = 1'b0;
                    if (accept_s) begin
                        vec_d = vec_pack_s;
                        if (din_first && (beat_cnt_q != 5'd0)) begin
                            beat_cnt_d = 5'd1;
                            err_d      = 1'b1;
                        end else if (!din_first && (beat_cnt_q == 5'd0)) begin
                            beat_cnt_d = 5'd1;
                            err_d      = 1'b1;
                        end else if (beat_cnt_q == 5'd31) begin
                            beat_cnt_d  = 5'd0;
                            state_d     = ST_HOLD;
                            din_ready_d = 1'b0;
                            vec_valid_d = 1'b1;
                        end else begin
                            beat_cnt_d = beat_cnt_q + 5'd1;
                        end
                    end else begin
                        vec_d = vec_q;
                    end
                end
                ST_HOLD: begin
                    if (vec_ready) begin
                        state_d     = ST_FILL;
                        din_ready_d = 1'b1;
                        vec_valid_d = 1'b0;
                    end else begin
                        din_ready_d = 1'b0;
                        vec_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_FILL;
                    din_ready_d = 1'b0;
                    vec_valid_d = 1'b0;
                    beat_cnt_d  = 5'd0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            din_ready_q <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_q       <= 255'd0;
            beat_cnt_q  <= 5'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            din_ready_q <= din_ready_d;
            vec_valid_q <= vec_valid_d;
            vec_q       <= vec_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
        end
    end

    assign din_ready = din_ready_q;
    assign vec_valid = vec_valid_q;
    assign vec       = vec_q;
    assign beat_cnt  = beat_cnt_q;
    assign err       = err_q;

endmodule
